// File: rtl/frequency_meter_pkg.sv
// frequency_meter_pkg: FSM encodings and sizing helpers shared by the frequency_meter files
package frequency_meter_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GATE  = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;
  function automatic int gate_cycles(input int clk_freq, input int gate_hz);
    return clk_freq / gate_hz;
  endfunction
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/frequency_meter_signal_synchronizer.sv
// signal_synchronizer: SYNC_STAGES-flop synchronizer followed by a registered rising-edge pulse
module signal_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_pulse
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  if (SYNC_STAGES < 2) begin : g_stage_check
    $error("SYNC_STAGES must be at least 2");
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= '0;
      prev       <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], din};
      prev       <= sync[SYNC_STAGES-1];
      rise_pulse <= sync[SYNC_STAGES-1] & ~prev;
    end
  end
endmodule

// File: rtl/frequency_meter.sv
// frequency_meter: gated rising-edge counter on SignalIn; FREQ_METER_SCALE_EN reports Count in Hz
module frequency_meter
  import frequency_meter_pkg::*;
#(
  parameter int CLK_FREQ    = 100000000,
  parameter int GATE_HZ     = 1,
  parameter int COUNT_BITS  = 28,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  InputCLK,
  input  logic                  Reset,
  input  logic                  SignalIn,
  input  logic                  Enable,
  output logic [COUNT_BITS-1:0] Count,
  output logic                  Valid,
  output logic                  Overflow
);
  localparam int GATE_CYCLES = gate_cycles(CLK_FREQ, GATE_HZ);
  localparam int GW = clog2(GATE_CYCLES);
  if (GATE_CYCLES < 2) begin : g_gate_check
    $error("GATE_CYCLES must be at least 2");
  end
  logic [1:0] state;
  logic [GW-1:0] gate_cnt;
  logic [COUNT_BITS-1:0] edge_cnt;
  logic sat;
  logic rise;
  logic [COUNT_BITS-1:0] result;
  logic result_ovf;
  signal_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(InputCLK),
    .rst(Reset),
    .din(SignalIn),
    .rise_pulse(rise)
  );
`ifdef FREQ_METER_SCALE_EN
  localparam int PW = COUNT_BITS + clog2(GATE_HZ + 1);
  logic [PW-1:0] prod;
  assign prod       = PW'(edge_cnt) * PW'(GATE_HZ);
  assign result     = prod[COUNT_BITS-1:0];
  assign result_ovf = sat | (|prod[PW-1:COUNT_BITS]);
`else
  assign result     = edge_cnt;
  assign result_ovf = sat;
`endif
  // sat marks an increment attempted while edge_cnt was already at full scale
  always_ff @(posedge InputCLK) begin
    if (Reset) begin
      state    <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
      Count    <= '0;
      Valid    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      Valid <= 1'b0;
      if (state == GATE && Enable) begin
        gate_cnt <= gate_cnt + 1'b1;
        if (rise && edge_cnt == '1) sat <= 1'b1;
        else if (rise) edge_cnt <= edge_cnt + 1'b1;
        if (gate_cnt == GW'(GATE_CYCLES - 1)) state <= LATCH;
      end else begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        sat      <= 1'b0;
        state    <= Enable && state != GATE ? GATE : IDLE;
      end
      if (state == LATCH) begin
        Count    <= result;
        Overflow <= result_ovf;
        Valid    <= 1'b1;
      end
    end
  end
endmodule
